// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor and its testbench.
//   - state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
//   - cnt_width : width of the bit counter for an n-bit operand
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter holds 0..n-1; one extra bit keeps it wide enough for any n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// -----------------------------------------------------------------------------
// fullsub
//   Purely combinational 1-bit full subtractor: d = x - y - bin.
//   Ports:
//     bin  in  borrow in
//     x    in  minuend bit
//     y    in  subtrahend bit
//     d    out difference bit
//     bout out borrow out
// -----------------------------------------------------------------------------
module fullsub (
  input  logic bin,
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing D = X - Y - borrowin (modulo 2^n), one bit
//   per clock, LSB first, using a single fullsub cell.
//
//   Parameter:
//     n          operand / result width (n >= 2, default 8)
//   Ports:
//     clk        clock, rising edge
//     reset      synchronous active-high reset
//     start      request a new subtraction (accepted only in IDLE)
//     X, Y       minuend / subtrahend, sampled when start is accepted
//     borrowin   borrow into bit 0, sampled with X and Y
//     D          registered difference, held until the next result
//     borrowout  registered borrow out of bit n-1
//     busy       high while an operation is in progress
//     done       one-cycle pulse marking a valid result on D/borrowout
//     overflow   (only with SERIAL_SUBTRACTOR_OVERFLOW_EN) signed overflow
//
//   Configuration macro: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the overflow port.
//
//   Timing: start accepted at edge 0, bits processed at edges 1..n, result
//   copied to D/borrowout at edge n, done visible after edge n+1.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  input  logic         borrowin,
  output logic [n-1:0] D,
  output logic         borrowout,
  output logic         busy,
  output logic         done
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int unsigned CW = cnt_width(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [n-1:0]    xr;        // latched minuend, shifted right each RUN cycle
  logic [n-1:0]    yr;        // latched subtrahend, shifted right each RUN cycle
  logic            b;         // running borrow
  // Only n-1 bits are stored: the last difference bit goes straight into D
  // from sr_next, so the LSB of a full-width register would never be read.
  logic [n-2:0]    sr;
  logic [n-1:0]    sr_next;
  logic            d_bit;
  logic            b_next;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic            x_msb;
  logic            y_msb;
`endif

  fullsub u_fullsub (
    .bin  (b),
    .x    (xr[0]),
    .y    (yr[0]),
    .d    (d_bit),
    .bout (b_next)
  );

  always_comb begin
    sr_next = {d_bit, sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      b         <= 1'b0;
      sr        <= '0;
      D         <= '0;
      borrowout <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      x_msb     <= 1'b0;
      y_msb     <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      // Status flags are registered from the current state, so they trail the
      // state by one cycle: done then coincides with D being stable.
      busy <= (state != IDLE);
      done <= (state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            xr    <= X;
            yr    <= Y;
            b     <= borrowin;
            cnt   <= '0;
            sr    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            x_msb <= X[n-1];
            y_msb <= Y[n-1];
`endif
            state <= RUN;
          end
        end

        RUN: begin
          xr  <= xr >> 1;
          yr  <= yr >> 1;
          b   <= b_next;
          sr  <= sr_next[n-1:1];
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            D         <= sr_next;
            borrowout <= b_next;
            state     <= DONE;
          end
        end

        DONE: begin
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          overflow <= (x_msb != y_msb) & (D[n-1] != x_msb);
`endif
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor with n = 8.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] X;
  logic [7:0] Y;
  logic       borrowin;
  logic [7:0] D;
  logic       borrowout;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic       overflow;
`endif

  int n_compared;
  int n_mismatched;

  serial_subtractor #(.n(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .borrowin  (borrowin),
    .D         (D),
    .borrowout (borrowout),
    .busy      (busy),
    .done      (done)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: plain; mode 1: scramble inputs after acceptance;
  // mode 2: pulse start with other operands during RUN cycle 3.
  task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic bin, input logic [7:0] exp_d, input logic exp_bo,
                       input int mode);
    int edges;
    int busy_n;
    int done_n;
    int lat;
    logic [7:0] d_before;
    d_before = D;
    @(negedge clk);
    X = x; Y = y; borrowin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mode == 1) begin
      X = ~x; Y = ~y; borrowin = ~bin;
    end
    edges = 0; busy_n = 0; done_n = 0; lat = 0;
    while (edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = edges;
      end
      if (edges == 1) check({tag, "_state_run"}, 32'(dut.state), 32'(RUN));
      if (edges == 4) check({tag, "_d_hold"}, 32'(D), 32'(d_before));
      if (mode == 2 && edges == 3) begin
        start = 1'b1; X = 8'h01; Y = 8'h02; borrowin = 1'b0;
      end
      if (mode == 2 && edges == 4) start = 1'b0;
    end
    check({tag, "_d"}, 32'(D), 32'(exp_d));
    check({tag, "_bo"}, 32'(borrowout), 32'(exp_bo));
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    reset = 1'b1; start = 1'b0; X = '0; Y = '0; borrowin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", 32'(D), 32'h0);
    check("rst_bo", 32'(borrowout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("rst_ovf", 32'(overflow), 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    do_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("ovf_05_03", 32'(overflow), 32'h0);
`endif
    do_op("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0);
    do_op("sub_10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 0);
    do_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0);
    do_op("sub_ff_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 0);
    do_op("sub_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 0);
    do_op("scramble", 8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0);
    check("ovf_80_01", 32'(overflow), 32'h1);
    do_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 0);
    check("ovf_7f_ff", 32'(overflow), 32'h1);
`endif
    do_op("restart_ign", 8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 2);

    // Reset during RUN cycle 4 aborts the operation with no done pulse.
    begin
      int done_n;
      @(negedge clk);
      X = 8'h55; Y = 8'h11; borrowin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_d", 32'(D), 32'h0);
      check("abort_bo", 32'(borrowout), 32'h0);
      check("abort_state", 32'(dut.state), 32'(IDLE));
      done_n = 0;
      if (done) done_n++;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done) done_n++;
      end
      check("abort_no_done", 32'(done_n), 32'h0);
    end
    do_op("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter n, default 8, SHALL set the operand and result width in bits (n >= 2).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port start, input, 1 bit, SHALL request a new subtraction D = X - Y - borrowin.
REQ-005 Ports X and Y, input, n bits each, SHALL be the minuend and subtrahend (X[n-1] is the MSB); they are sampled only when start is accepted.
REQ-006 Port borrowin, input, 1 bit, SHALL be the borrow into bit 0; it is sampled with X and Y.
REQ-007 Port D, output, n bits, SHALL be the registered difference.
REQ-008 Port borrowout, output, 1 bit, SHALL be the registered borrow out of bit n-1.
REQ-009 Port busy, output, 1 bit, SHALL be high while an operation is in progress.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle pulse marking a valid result.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch X, Y and borrowin, clear the bit counter and the result shift register, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-014 Each RUN cycle SHALL process bit k (LSB first) as follows:
- difference bit: d = x ^ y ^ b
- next borrow: b' = (~x & y) | (~x & b) | (y & b)
- d is shifted in at the MSB of the result shift register.
REQ-015 RUN SHALL last exactly n cycles (counter values 0 to n-1), then go to DONE.
REQ-016 On the transition into DONE, the shift register SHALL be copied to D and the final borrow to borrowout.
REQ-017 done SHALL be high for exactly the single DONE cycle; the FSM then returns to IDLE unconditionally.
REQ-018 With start accepted at edge 0, done SHALL be high in the cycle following edge n+1, giving a latency of n+1 cycles.
REQ-019 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; a held start is accepted in the first IDLE cycle.
REQ-021 D and borrowout SHALL hold their value from the last DONE until the next DONE; they SHALL NOT change during RUN.
REQ-022 Input changes on X, Y or borrowin after acceptance SHALL NOT affect the result in progress.
REQ-023 Arithmetic SHALL be modulo 2^n; borrowout=1 exactly when the unsigned value X < Y + borrowin.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL:
- force the FSM to IDLE
- clear the counter, shift register, borrow flop, D and borrowout to 0
- drive busy=0 and done=0.
REQ-025 A reset arriving mid-RUN SHALL abort the operation with no done pulse, and the block SHALL accept a new start on the first cycle after reset deasserts.
REQ-026 reset SHALL take priority over start.

Configuration
REQ-027 When macro SERIAL_SUBTRACTOR_OVERFLOW_EN is defined, the block SHALL add a registered output overflow (1 bit, reset 0), set in DONE to (X[n-1] != Y[n-1]) & (D[n-1] != X[n-1]) using the latched operands.
REQ-028 When SERIAL_SUBTRACTOR_OVERFLOW_EN is undefined, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The FSM state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) SHALL be defined once as constants in the shared subtractor package and used by both the RTL and the bench.
REQ-030 The 1-bit cell SHALL be a sub-module fullsub (ports bin, x, y, d, bout) that is purely combinational and instanced once.
REQ-031 The counter width SHALL be clog2(n)+1 bits.

Verification (n=8)
REQ-032 X=0x05, Y=0x03, borrowin=0 -> D=0x02, borrowout=0, done high exactly 9 cycles after acceptance, busy high for 9 cycles.
REQ-033 X=0x00, Y=0x01, borrowin=0 -> D=0xFF, borrowout=1.
REQ-034 X=0x10, Y=0x0F, borrowin=1 -> D=0x00, borrowout=0.
REQ-035 With the macro defined, X=0x80, Y=0x01 -> D=0x7F, overflow=1; and X=0x7F, Y=0xFF -> D=0x80, overflow=1, borrowout=1.
REQ-036 Start a subtraction, pulse start again at RUN cycle 3 with different operands -> only the first result appears, with a single done pulse.
REQ-037 Assert reset at RUN cycle 4 -> busy=0, D=0x00 and no done pulse; a following start with 0x09-0x04 -> D=0x05 after 9 cycles.
